// File: rtl/fire2_3_expand1_ofm_writer.sv
// Output feature-map writer for the fire2/fire3 expand-1x1 stage: captures 64-channel
// pixel vectors into a ping-pong buffer and streams them LANES channels per RAM write.
module fire2_3_expand1_ofm_writer #(
  parameter int WIDTH  = 16,
  parameter int CH_NO  = 64,
  parameter int WOUT   = 64,
  parameter int LANES  = 4,
  parameter int BEATS  = CH_NO / LANES,
  parameter int ADDR_W = $clog2(WOUT * WOUT * BEATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   layer_start,
  input  logic                   layer_sel,
  input  logic                   sample_i,
  input  logic [WIDTH-1:0]       ofm_i [0:CH_NO-1],
  output logic                   wr_en_o,
  output logic [ADDR_W-1:0]      wr_addr_o,
  output logic [LANES*WIDTH-1:0] wr_data_o,
  output logic                   ram_feedback_2_o,
  output logic                   ram_feedback_3_o,
  output logic                   busy_o,
  output logic                   overflow_o
);

  localparam int PIXELS = WOUT * WOUT;
  localparam int PIX_W  = $clog2(PIXELS + 1);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CH_W   = (CH_NO > 1) ? $clog2(CH_NO) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       pp_mem [0:1][0:CH_NO-1];
  logic [1:0]             vld, vld_nxt;
  logic                   wptr, rptr, sel;
  logic [BEAT_W-1:0]      beat;
  logic [PIX_W-1:0]       pixel_cnt, held_cnt;
  logic                   active, issue, last_beat, slot_free, accept, drop, done;
  logic [ADDR_W-1:0]      beat_addr;
  logic [LANES*WIDTH-1:0] beat_data;

  // Datapath control: beat issue, capture acceptance and layer completion
  always_comb begin
    active    = (state == RUN) && !layer_start;
    issue     = active && vld[rptr];
    last_beat = issue && (beat == BEAT_W'(BEATS - 1));
    // pixels written plus pixels waiting in the buffer; caps capture at one layer
    held_cnt  = pixel_cnt + PIX_W'(vld[0]) + PIX_W'(vld[1]);
    slot_free = !vld[wptr] || (last_beat && (wptr == rptr));
    accept    = active && sample_i && slot_free && (held_cnt < PIX_W'(PIXELS));
    drop      = active && sample_i && !accept;
    done      = active && (pixel_cnt == PIX_W'(PIXELS));
    vld_nxt          = vld;
    vld_nxt[rptr]    = vld[rptr] & ~last_beat;
    vld_nxt[wptr]    = vld_nxt[wptr] | accept;
    beat_addr = ADDR_W'(pixel_cnt) * ADDR_W'(BEATS) + ADDR_W'(beat);
    beat_data = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_data[l*WIDTH +: WIDTH] = pp_mem[rptr][CH_W'(int'(beat) * LANES + l)];
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = layer_start ? RUN : IDLE;
      RUN:     state_nxt = (done && !layer_start) ? IDLE : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Ping-pong vector storage
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < CH_NO; k++) begin
        pp_mem[wptr][k] <= ofm_i[k];
      end
    end
  end

  // State, buffer bookkeeping and counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      vld        <= 2'b00;
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      beat       <= '0;
      pixel_cnt  <= '0;
      overflow_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (layer_start) begin
        sel        <= layer_sel;
        vld        <= 2'b00;
        wptr       <= 1'b0;
        rptr       <= 1'b0;
        beat       <= '0;
        pixel_cnt  <= '0;
        overflow_o <= 1'b0;
      end else begin
        vld <= vld_nxt;
        if (accept) wptr <= ~wptr;
        if (issue) beat <= last_beat ? '0 : beat + BEAT_W'(1);
        if (last_beat) begin
          rptr      <= ~rptr;
          pixel_cnt <= pixel_cnt + PIX_W'(1);
        end
        if (drop) overflow_o <= 1'b1;
      end
    end
  end

  // Registered RAM write port and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en_o          <= 1'b0;
      wr_addr_o        <= '0;
      wr_data_o        <= '0;
      ram_feedback_2_o <= 1'b0;
      ram_feedback_3_o <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      wr_en_o          <= issue;
      if (issue) begin
        wr_addr_o <= beat_addr;
        wr_data_o <= beat_data;
      end
      ram_feedback_2_o <= done && !sel;
      ram_feedback_3_o <= done && sel;
      busy_o           <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_fire2_3_expand1_ofm_writer.sv
// Scoreboard bench for fire2_3_expand1_ofm_writer: a timeline model predicts every RAM
// write (cycle, address, data) and the completion pulse; a negedge monitor checks them.
module tb_fire2_3_expand1_ofm_writer;
  localparam int WIDTH = 16, CH_NO = 64, WOUT = 64, LANES = 4;
  localparam int BEATS = 16, ADDR_W = 16, PIXELS = WOUT * WOUT;

  typedef logic [WIDTH-1:0] vec_t [0:CH_NO-1];
  typedef struct {
    int                     cyc;
    logic [ADDR_W-1:0]      addr;
    logic [LANES*WIDTH-1:0] data;
  } wr_t;

  logic clk = 1'b0, rst = 1'b0, layer_start = 1'b0, layer_sel = 1'b0, sample_i = 1'b0;
  vec_t ofm_i;
  logic                   wr_en_o, ram_feedback_2_o, ram_feedback_3_o, busy_o, overflow_o;
  logic [ADDR_W-1:0]      wr_addr_o;
  logic [LANES*WIDTH-1:0] wr_data_o;

  fire2_3_expand1_ofm_writer #(.WIDTH(WIDTH), .CH_NO(CH_NO), .WOUT(WOUT), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .layer_sel(layer_sel),
    .sample_i(sample_i), .ofm_i(ofm_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .ram_feedback_2_o(ram_feedback_2_o),
    .ram_feedback_3_o(ram_feedback_3_o), .busy_o(busy_o), .overflow_o(overflow_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0, n_writes = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  wr_t exp_q[$];

  // reference model state
  bit m_run = 1'b0, m_ovf = 1'b0, m_sel = 1'b0;
  int m_acc = 0, m_last1 = 0, m_last2 = 0, exp_fb_cyc = -1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic bit m_running(int t);
    return m_run && !(exp_fb_cyc >= 0 && t > exp_fb_cyc);
  endfunction

  // A pixel holds a buffer from capture until its last beat; a buffer whose last beat
  // is at the capture edge counts as free. Writes follow the previous pixel back to back.
  function automatic int model_sample(int t, vec_t v);
    int occ, first;
    wr_t w;
    if (!m_running(t)) return -1;
    occ = int'(m_last1 > t) + int'(m_last2 > t);
    if (occ >= 2 || m_acc >= PIXELS) begin
      m_ovf = 1'b1;
      return -1;
    end
    first = (t + 1 > m_last1 + 1) ? t + 1 : m_last1 + 1;
    for (int b = 0; b < BEATS; b++) begin
      w.cyc  = first + b;
      w.addr = ADDR_W'(m_acc * BEATS + b);
      w.data = '0;
      for (int l = 0; l < LANES; l++) w.data[l*WIDTH +: WIDTH] = v[b*LANES + l];
      exp_q.push_back(w);
    end
    m_last2 = m_last1;
    m_last1 = first + BEATS - 1;
    m_acc++;
    if (m_acc == PIXELS) exp_fb_cyc = m_last1 + 1;
    return first;
  endfunction

  function automatic void model_start(int t, bit s);
    m_run = 1'b1; m_sel = s; m_acc = 0; m_last1 = t; m_last2 = t;
    m_ovf = 1'b0; exp_fb_cyc = -1;
    exp_q.delete();
  endfunction

  function automatic void model_reset();
    m_run = 1'b0; m_ovf = 1'b0; m_acc = 0; exp_fb_cyc = -1;
    exp_q.delete();
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < CH_NO; k++) v[k] = WIDTH'($urandom);
    return v;
  endfunction

  // monitor: scoreboard of writes and completion pulses
  always @(negedge clk) begin
    wr_t w;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      w = exp_q.pop_front();
      check("missing_write_addr", 64'(w.addr) | 64'h1_0000_0000, 64'(w.addr));
    end
    if (wr_en_o) begin
      n_writes++;
      last_addr = wr_addr_o;
      if (exp_q.size() == 0) check("unexpected_write", 64'(wr_addr_o) | 64'h1_0000_0000, 64'(wr_addr_o));
      else begin
        w = exp_q.pop_front();
        check("write_cycle", 64'(cyc), 64'(w.cyc));
        check("write_addr", 64'(wr_addr_o), 64'(w.addr));
        check("write_data", wr_data_o, w.data);
      end
    end
    if (exp_fb_cyc >= 0 && cyc == exp_fb_cyc) begin
      check("fb2_pulse", 64'(ram_feedback_2_o), 64'(!m_sel));
      check("fb3_pulse", 64'(ram_feedback_3_o), 64'(m_sel));
      check("busy_fall", 64'(busy_o), 64'd0);
    end else if (ram_feedback_2_o || ram_feedback_3_o) begin
      check("spurious_fb", 64'({ram_feedback_2_o, ram_feedback_3_o}), 64'd0);
    end
    if (exp_fb_cyc >= 0 && cyc == exp_fb_cyc - 1) check("busy_before_fb", 64'(busy_o), 64'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v, output int first);
    ofm_i = v;
    sample_i = 1'b1;
    first = model_sample(cyc + 1, v);
    tick();
    sample_i = 1'b0;
  endtask

  task automatic start_layer(input bit s);
    layer_start = 1'b1;
    layer_sel = s;
    tick();
    layer_start = 1'b0;
    model_start(cyc, s);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((exp_q.size() > 0 || (exp_fb_cyc >= 0 && cyc <= exp_fb_cyc)) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) check("drain_timeout", 64'(n), 64'(bound - 1));
  endtask

  initial begin
    vec_t v;
    int f, f0, f10, w0;
    for (int k = 0; k < CH_NO; k++) ofm_i[k] = '0;
    repeat (3) tick();
    check("rst_wr_en", 64'(wr_en_o), 64'd0);
    check("rst_addr", 64'(wr_addr_o), 64'd0);
    check("rst_data", wr_data_o, 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    check("rst_fb", 64'({ram_feedback_2_o, ram_feedback_3_o}), 64'd0);
    model_reset();
    rst = 1'b1;
    tick();

    // single pixel with ofm[k] = k
    start_layer(1'b0);
    check("busy_after_start", 64'(busy_o), 64'd1);
    for (int k = 0; k < CH_NO; k++) v[k] = WIDTH'(k);
    send(v, f);
    wait_drain(40);
    check("single_last_data", wr_data_o, 64'h003F_003E_003D_003C);
    check("single_ovf", 64'(overflow_o), 64'd0);

    // three back-to-back samples: third one dropped
    start_layer(1'b0);
    repeat (3) send(rand_vec(), f);
    wait_drain(60);
    check("b2b_ovf", 64'(overflow_o), 64'd1);
    check("b2b_last_addr", 64'(last_addr), 64'd31);

    // sample lands on the release cycle of a full buffer pair
    start_layer(1'b1);
    send(rand_vec(), f0);
    send(rand_vec(), f);
    while (cyc + 1 < f0 + BEATS - 1) tick();
    send(rand_vec(), f);
    check("collision_accepted", 64'(f >= 0), 64'd1);
    wait_drain(80);
    check("collision_ovf", 64'(overflow_o), 64'd0);
    check("collision_last_addr", 64'(last_addr), 64'd47);

    // random inter-sample gaps
    start_layer(1'($urandom));
    repeat (40) begin
      send(rand_vec(), f);
      repeat ($urandom_range(0, 20)) tick();
    end
    wait_drain(80);
    check("random_ovf", 64'(overflow_o), 64'(m_ovf));

    // restart mid-layer clears progress and overflow
    start_layer(1'b0);
    repeat (3) send(rand_vec(), f);
    repeat (97) begin
      repeat (16) tick();
      send(rand_vec(), f);
    end
    check("ovf_before_restart", 64'(overflow_o), 64'd1);
    start_layer(1'b0);
    check("ovf_cleared_restart", 64'(overflow_o), 64'd0);
    check("busy_restart", 64'(busy_o), 64'd1);
    send(rand_vec(), f);
    wait_drain(40);
    check("restart_last_addr", 64'(last_addr), 64'd15);

    // reset asserted during beat 5 of pixel 10
    start_layer(1'b1);
    f10 = 0;
    for (int p = 0; p <= 10; p++) begin
      send(rand_vec(), f);
      if (p == 10) f10 = f;
      else repeat (16) tick();
    end
    while (cyc < f10 + 5) tick();
    rst = 1'b0;
    tick();
    check("midrst_wr_en", 64'(wr_en_o), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_fb", 64'({ram_feedback_2_o, ram_feedback_3_o}), 64'd0);
    model_reset();
    rst = 1'b1;
    tick();
    start_layer(1'b0);
    send(rand_vec(), f);
    wait_drain(40);
    check("after_rst_last_addr", 64'(last_addr), 64'd15);

    // full fire3 layer at one sample per 17 cycles
    start_layer(1'b1);
    w0 = n_writes;
    for (int p = 0; p < PIXELS; p++) begin
      send(rand_vec(), f);
      if (p != PIXELS - 1) repeat (16) tick();
    end
    tick();
    check("full_ovf", 64'(overflow_o), 64'd0);
    send(rand_vec(), f);
    wait_drain(60);
    check("full_write_count", 64'(n_writes - w0), 64'(PIXELS * BEATS));
    check("full_last_addr", 64'(last_addr), 64'hFFFF);
    check("late_sample_ovf", 64'(overflow_o), 64'd1);
    check("full_busy_idle", 64'(busy_o), 64'd0);
    send(rand_vec(), f);
    repeat (20) tick();
    check("idle_sample_writes", 64'(n_writes - w0), 64'(PIXELS * BEATS));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fire2_3_expand1_ofm_writer.md
Name: fire2_3_expand1_ofm_writer

Overview:
- Downstream consumer of the fire2/fire3 expand-1x1 stage.
- On each sample pulse from that stage, captures the 64-channel output vector (one output pixel) into a two-entry ping-pong buffer.
- Serializes each captured vector into the feature-map RAM write port, LANES channels per beat, and generates addresses.
- Counts pixels and raises the per-layer RAM feedback pulse once the full 64x64x64 map has been written.

Parameters:
- WIDTH, 16, bits per channel value
- CH_NO, 64, channels per pixel (vector length)
- WOUT, 64, output map width; pixels per layer = WOUT*WOUT
- LANES, 4, channels packed per RAM write; CH_NO % LANES == 0
- BEATS, CH_NO/LANES (derived, 16), writes per pixel
- ADDR_W, $clog2(WOUT*WOUT*BEATS) (derived, 16), RAM address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- layer_start  in  1  one-cycle pulse; arms the writer for a new layer
- layer_sel  in  1  sampled on layer_start; 0 = fire2, 1 = fire3
- sample_i  in  1  one-cycle pulse; ofm_i is valid this cycle
- ofm_i  in  WIDTH x CH_NO (unpacked array [0:CH_NO-1])  expand output vector
- wr_en_o  out  1  RAM write strobe
- wr_addr_o  out  ADDR_W  RAM word address
- wr_data_o  out  LANES*WIDTH  packed channels; lowest channel in the LSBs
- ram_feedback_2_o  out  1  one-cycle pulse: fire2 layer fully written
- ram_feedback_3_o  out  1  one-cycle pulse: fire3 layer fully written
- busy_o  out  1  high while in RUN
- overflow_o  out  1  sticky; a sample was dropped

Behaviour:
- Reset (rst==0 at a clk edge):
  - State = IDLE.
  - All outputs = 0.
  - Buffer valid bits, pointers, beat counter and pixel counter = 0.
  - Reset takes priority over every other input, including mid-RUN: buffered data is discarded and no feedback pulse is produced.
- States:
  - IDLE -> RUN on layer_start. layer_sel is latched. Pixel counter, beat counter, both buffer valid bits and overflow_o are cleared.
  - RUN -> IDLE on the cycle after the last beat of pixel WOUT*WOUT-1 is written.
  - layer_start while in RUN restarts the layer: same clearing as from IDLE, stays in RUN, no feedback pulse.
  - sample_i in IDLE is ignored and does not set overflow.
- Capture:
  - In RUN, sample_i writes ofm_i into the buffer at the write pointer and sets its valid bit; the write pointer toggles.
  - Accepted when that buffer is free, or is being released this same cycle (its last beat is issued this cycle).
  - Otherwise the sample is dropped, overflow_o <= 1, and the pointer is not advanced.
- Serialization:
  - While the buffer at the read pointer is valid, one beat is issued per cycle, beat = 0..BEATS-1.
  - wr_data_o = {ofm[b*LANES+LANES-1], ..., ofm[b*LANES]}.
  - wr_addr_o = pixel_cnt*BEATS + b.
  - wr_en_o = 1 for that cycle. All three outputs are registered.
  - On beat BEATS-1: clear the valid bit, toggle the read pointer, increment pixel_cnt.
  - Next buffer, if valid, starts on the following cycle with no bubble.
- Latency:
  - sample_i at edge t, buffer empty: first wr_en_o high in cycle t+1.
  - One pixel occupies BEATS consecutive cycles.
  - Sustained throughput is one sample per BEATS cycles. The expand stage delivers one sample per 17 cycles, so no overflow occurs in normal use.
- Completion:
  - The cycle after the final write (address WOUT*WOUT*BEATS-1), exactly one of ram_feedback_2_o / ram_feedback_3_o (per latched layer_sel) pulses high for 1 cycle.
  - busy_o falls in the same cycle as that pulse.
  - Samples arriving after the final pixel is captured, while still in RUN, are dropped and set overflow.
- pixel_cnt does not wrap; the layer ends exactly at WOUT*WOUT pixels.

Test Plan:
- Single pixel: reset, layer_start with sel=0, one sample with ofm_i[k]=k.
  - Expect wr_en_o high for cycles t+1..t+16, addresses 0..15.
  - Beat 0 data = 0x0003_0002_0001_0000; beat 15 data = 0x003F_003E_003D_003C.
- Full layer, sel=1, samples every 17 cycles, 4096 pixels:
  - Expect 65536 writes, last wr_addr_o = 0xFFFF, overflow_o = 0.
  - ram_feedback_3_o pulses exactly once, 1 cycle after the last write; ram_feedback_2_o stays 0; busy_o falls in the same cycle.
- Back-to-back samples in 3 consecutive cycles:
  - First two are accepted; third is dropped and overflow_o = 1.
  - 32 writes follow with addresses 0..31; pixel 1 data equals the second vector.
- Release/capture collision: both buffers full, sample arrives on the cycle beat 15 is issued.
  - Sample is accepted, no overflow, and its writes follow the remaining buffer.
- Reset mid-run: assert rst=0 during beat 5 of pixel 10.
  - Next cycle: wr_en_o = 0, busy_o = 0, no feedback pulse.
  - A new layer_start writes again from address 0.
- Restart in RUN: layer_start at pixel 100.
  - pixel_cnt returns to 0 and overflow_o is cleared.
  - Next sample writes addresses 0..15 and no feedback pulse is produced for the aborted layer.
